// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, multi-cycle multiply stall and
// branch/jump flush arbitration, with saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        IDEX_MemRead_i,
  input  logic [4:0]  IDEX_RegRt_i,
  input  logic [4:0]  IFID_RegRs_i,
  input  logic [4:0]  IFID_RegRt_i,
  input  logic        Branch_taken_i,
  input  logic        Jump_i,
  input  logic        MulStart_i,
  output logic        PC_write_o,
  output logic        IFID_write_o,
  output logic        IDEX_write_o,
  output logic        IFID_flush_o,
  output logic        IDEX_bubble_o,
  output logic        EXMEM_bubble_o,
  output logic        Busy_o,
  output logic [15:0] StallCnt_o,
  output logic [15:0] FlushCnt_o
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PERF_W = 16;
  localparam int unsigned REG_W  = 5;

  // The wait state is only needed when the multiply outlasts its start cycle
  // plus one; a two-cycle multiply is covered by the start-cycle stall alone.
  localparam bit               MUL_WAIT_EN = (MUL_CYCLES >= 32'd3);
  localparam logic [CNT_W-1:0] MUL_LOAD    = CNT_W'(MUL_CYCLES - 32'd2);
  localparam logic [PERF_W-1:0] PERF_MAX   = '1;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   mul_cnt_q, mul_cnt_d;
  logic               busy_q, busy_d;
  logic [PERF_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic mul_stall;

  // Hazard detection; register 0 is hard-wired and never creates a dependency.
  always_comb begin
    load_use  = IDEX_MemRead_i
              && (IDEX_RegRt_i != REG_W'(0))
              && ((IDEX_RegRt_i == IFID_RegRs_i) || (IDEX_RegRt_i == IFID_RegRt_i));
    mul_stall = (state_q == MUL_WAIT) || ((state_q == RUN) && MulStart_i);
  end

  // Pipeline control: reset > multiply stall > load-use > branch/jump flush.
  always_comb begin
    PC_write_o     = 1'b1;
    IFID_write_o   = 1'b1;
    IDEX_write_o   = 1'b1;
    IFID_flush_o   = 1'b0;
    IDEX_bubble_o  = 1'b0;
    EXMEM_bubble_o = 1'b0;
    if (rst_i) begin
      PC_write_o     = 1'b0;
      IFID_write_o   = 1'b0;
      IDEX_write_o   = 1'b0;
      IFID_flush_o   = 1'b1;
      IDEX_bubble_o  = 1'b1;
      EXMEM_bubble_o = 1'b1;
    end else if (mul_stall) begin
      PC_write_o     = 1'b0;
      IFID_write_o   = 1'b0;
      IDEX_write_o   = 1'b0;
      EXMEM_bubble_o = 1'b1;
    end else if (load_use) begin
      PC_write_o    = 1'b0;
      IFID_write_o  = 1'b0;
      IDEX_bubble_o = 1'b1;
    end else begin
      IFID_flush_o = Branch_taken_i || Jump_i;
    end
  end

  // Multiply sequencing; MulStart_i is ignored while already waiting.
  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    case (state_q)
      RUN: begin
        if (MulStart_i && MUL_WAIT_EN) begin
          state_d   = MUL_WAIT;
          mul_cnt_d = MUL_LOAD;
        end
      end
      MUL_WAIT: begin
        mul_cnt_d = mul_cnt_q - CNT_W'(1);
        if (mul_cnt_q == CNT_W'(1)) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d   = RUN;
        mul_cnt_d = '0;
      end
    endcase
    busy_d = (state_d == MUL_WAIT);
  end

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!PC_write_o && (stall_cnt_q != PERF_MAX)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
    if (IFID_flush_o && (flush_cnt_q != PERF_MAX)) begin
      flush_cnt_d = flush_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      mul_cnt_q   <= '0;
      busy_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mul_cnt_q   <= mul_cnt_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Busy_o     = busy_q;
  assign StallCnt_o = stall_cnt_q;
  assign FlushCnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed and random stimulus checked
// against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MC = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        IDEX_MemRead_i = 1'b0;
  logic [4:0]  IDEX_RegRt_i = 5'd0;
  logic [4:0]  IFID_RegRs_i = 5'd0;
  logic [4:0]  IFID_RegRt_i = 5'd0;
  logic        Branch_taken_i = 1'b0;
  logic        Jump_i = 1'b0;
  logic        MulStart_i = 1'b0;
  logic        PC_write_o, IFID_write_o, IDEX_write_o, IFID_flush_o;
  logic        IDEX_bubble_o, EXMEM_bubble_o, Busy_o;
  logic [15:0] StallCnt_o, FlushCnt_o;

  pipe_hazard_ctrl #(.MUL_CYCLES(MC)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .IDEX_MemRead_i (IDEX_MemRead_i),
    .IDEX_RegRt_i   (IDEX_RegRt_i),
    .IFID_RegRs_i   (IFID_RegRs_i),
    .IFID_RegRt_i   (IFID_RegRt_i),
    .Branch_taken_i (Branch_taken_i),
    .Jump_i         (Jump_i),
    .MulStart_i     (MulStart_i),
    .PC_write_o     (PC_write_o),
    .IFID_write_o   (IFID_write_o),
    .IDEX_write_o   (IDEX_write_o),
    .IFID_flush_o   (IFID_flush_o),
    .IDEX_bubble_o  (IDEX_bubble_o),
    .EXMEM_bubble_o (EXMEM_bubble_o),
    .Busy_o         (Busy_o),
    .StallCnt_o     (StallCnt_o),
    .FlushCnt_o     (FlushCnt_o)
  );

  always #5 clk = ~clk;

  // ctrl = {pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, exmem_bubble}
  typedef struct {
    int         cyc;
    logic [5:0] ctrl;
    logic       busy;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t sb_q[$];
  exp_t e_pop;
  exp_t e_new;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Model state: stall cycles still owed to an in-flight multiply, plus counts.
  int mul_left = 0;
  int m_stall  = 0;
  int m_flush  = 0;

  task automatic step(input logic r, input logic mr, input logic [4:0] rt,
                      input logic [4:0] rs1, input logic [4:0] rt1,
                      input logic br, input logic jp, input logic ms);
    logic lu, in_mul, start;
    @(posedge clk);
    #1;
    cycle++;
    rst_i = r; IDEX_MemRead_i = mr; IDEX_RegRt_i = rt;
    IFID_RegRs_i = rs1; IFID_RegRt_i = rt1;
    Branch_taken_i = br; Jump_i = jp; MulStart_i = ms;

    e_new.cyc = cycle;
    if (r) begin
      mul_left = 0; m_stall = 0; m_flush = 0;
      e_new.ctrl = 6'b000111; e_new.busy = 1'b0;
      e_new.sc = 16'd0; e_new.fc = 16'd0;
    end else begin
      lu     = mr && (rt != 5'd0) && ((rt == rs1) || (rt == rt1));
      in_mul = (mul_left > 0);
      start  = !in_mul && ms;
      e_new.busy = in_mul;
      e_new.sc   = 16'(m_stall);
      e_new.fc   = 16'(m_flush);
      if (in_mul || start)  e_new.ctrl = 6'b000001;
      else if (lu)          e_new.ctrl = 6'b001010;
      else                  e_new.ctrl = {3'b111, br | jp, 2'b00};
      if (start)       mul_left = int'(MC) - 2;
      else if (in_mul) mul_left = mul_left - 1;
      if (!e_new.ctrl[5]) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      if (e_new.ctrl[2])  m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
    end
    sb_q.push_back(e_new);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents a control word; compare with the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e_pop = sb_q.pop_front();
        checks++;
        if ({PC_write_o, IFID_write_o, IDEX_write_o, IFID_flush_o, IDEX_bubble_o,
             EXMEM_bubble_o} !== e_pop.ctrl) begin
          errors++;
          $display("FAIL ctrl cyc=%0d got=%b exp=%b", e_pop.cyc,
                   {PC_write_o, IFID_write_o, IDEX_write_o, IFID_flush_o,
                    IDEX_bubble_o, EXMEM_bubble_o}, e_pop.ctrl);
        end
        checks++;
        if (Busy_o !== e_pop.busy) begin
          errors++;
          $display("FAIL busy cyc=%0d got=%b exp=%b", e_pop.cyc, Busy_o, e_pop.busy);
        end
        checks++;
        if (StallCnt_o !== e_pop.sc) begin
          errors++;
          $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", e_pop.cyc, StallCnt_o, e_pop.sc);
        end
        checks++;
        if (FlushCnt_o !== e_pop.fc) begin
          errors++;
          $display("FAIL flush_cnt cyc=%0d got=%0d exp=%0d", e_pop.cyc, FlushCnt_o, e_pop.fc);
        end
      end
    end
  end

  initial begin
    // Reset for two cycles
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(1);

    // Load x5 followed by a reader of x5, then a clean cycle
    step(1'b0, 1'b1, 5'd5, 5'd5, 5'd2, 1'b0, 1'b0, 1'b0);
    idle(1);
    // Reader through rt
    step(1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0);
    // Load to x0 never stalls
    step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Multiply pulse then quiet cycles
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle(4);

    // Branch held behind a load-use, then re-resolved
    step(1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);

    // Multiply with start re-asserted while waiting, and a branch during the wait
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1);
    idle(3);

    // Reset in the first wait cycle of a multiply aborts it
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Randomised traffic over a small register range to hit matches and x0 often
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 1) == 1),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 9) == 0));
    end

    // Drive the stall counter into saturation and beyond
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) step(1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle(4);

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: MUL_CYCLES, 4, total EX occupancy of a multiply in cycles; legal range 2..15.
REQ-002 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  in  1  reset, asynchronous and active-high.
REQ-004 IDEX_MemRead_i  in  1  instruction in EX is a load.
REQ-005 IDEX_RegRt_i  in  5  destination register of the EX-stage load.
REQ-006 IFID_RegRs_i, IFID_RegRt_i  in  5 each  source registers of the ID-stage instruction.
REQ-007 Branch_taken_i, Jump_i  in  1 each  control transfer resolved in ID.
REQ-008 MulStart_i  in  1  single-cycle pulse, first EX cycle of a multiply; input contract: never high in any other cycle.
REQ-009 PC_write_o, IFID_write_o, IDEX_write_o  out  1 each  pipeline register write enables.
REQ-010 IFID_flush_o  out  1  clear IF/ID to NOP at next edge.
REQ-011 IDEX_bubble_o, EXMEM_bubble_o  out  1 each  load zeroed control fields into ID/EX or EX/MEM at next edge.
REQ-012 Busy_o  out  1  high while in MUL_WAIT.
REQ-013 StallCnt_o, FlushCnt_o  out  16 each  saturating performance counters.

Function
REQ-014 States: RUN, MUL_WAIT; 4-bit down-counter mul_cnt.
REQ-015 load_use = IDEX_MemRead_i & (IDEX_RegRt_i != 0) & (IDEX_RegRt_i == IFID_RegRs_i | IDEX_RegRt_i == IFID_RegRt_i); register 0 never causes a stall.
REQ-016 mul_stall = (state == MUL_WAIT) | (state == RUN & MulStart_i).
REQ-017 Priority mul_stall > load_use > flush; evaluated combinationally each cycle.
REQ-018 mul_stall: PC_write_o=0, IFID_write_o=0, IDEX_write_o=0, EXMEM_bubble_o=1, IDEX_bubble_o=0, IFID_flush_o=0.
REQ-019 load_use (no mul_stall): PC_write_o=0, IFID_write_o=0, IDEX_write_o=1, IDEX_bubble_o=1, EXMEM_bubble_o=0, IFID_flush_o=0; exactly one bubble per load-use pair.
REQ-020 Neither: all write enables 1, both bubbles 0, IFID_flush_o = Branch_taken_i | Jump_i.
REQ-021 Branch_taken_i/Jump_i are ignored whenever PC_write_o=0; the held branch re-resolves when released.
REQ-022 RUN -> MUL_WAIT on an edge with MulStart_i=1 and MUL_CYCLES>=3, loading mul_cnt=MUL_CYCLES-2; with MUL_CYCLES=2 stay in RUN.
REQ-023 In MUL_WAIT, mul_cnt decrements each edge; when mul_cnt==1 at an edge, next state RUN.
REQ-024 Total front-end stall for one multiply = exactly MUL_CYCLES-1 cycles; ID/EX advances in cycle MUL_CYCLES-1 (counted from 0).
REQ-025 MulStart_i is ignored in MUL_WAIT.
REQ-026 StallCnt_o increments on each edge where PC_write_o=0 and rst_i=0; saturates at 0xFFFF.
REQ-027 FlushCnt_o increments on each edge where IFID_flush_o=1; saturates at 0xFFFF.
REQ-028 Busy_o is registered state decode, no combinational path from inputs.

Reset
REQ-029 While rst_i=1: state=RUN, mul_cnt=0, StallCnt_o=0, FlushCnt_o=0, Busy_o=0, independent of clk_i.
REQ-030 While rst_i=1: PC_write_o=0, IFID_write_o=0, IDEX_write_o=0, IFID_flush_o=1, IDEX_bubble_o=1, EXMEM_bubble_o=1.
REQ-031 Reset asserted mid-MUL_WAIT aborts the multiply; after deassertion the block is in RUN with no residual stall.

Verification
REQ-032 Load x5 in EX, ID reads rs=x5 -> one cycle with PC_write_o=0, IDEX_bubble_o=1; next cycle all enables 1; StallCnt_o=1.
REQ-033 Load to x0, ID reads rs=x0 -> no stall, all enables 1.
REQ-034 MUL_CYCLES=4, MulStart_i pulse in cycle 0 -> PC_write_o=0 and IDEX_write_o=0 in cycles 0-2, Busy_o=1 in cycles 1-2, RUN in cycle 3; StallCnt_o=3.
REQ-035 Branch_taken_i=1 coincident with load_use -> IFID_flush_o=0 that cycle; next cycle IFID_flush_o=1, FlushCnt_o=1.
REQ-036 Reset asserted in cycle 1 of MUL_WAIT -> Busy_o falls without clock edge, counters 0; after release, MulStart_i=0 gives all enables 1.
REQ-037 StallCnt_o preloaded to 0xFFFF via 65535 stall cycles, then further stall -> value stays 0xFFFF.
